// File: rtl/rv64_pkg.sv
// Shared types for the rv64 memory arbiter: engine states, grant encoding, AXI response codes.
// No logic here; imported by the arbiter, its grant selector and the bench.
package rv64_pkg;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_RESP} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_BACK} wr_state_e;
    typedef enum logic {GrantIm = 1'b0, GrantDm = 1'b1} grant_e;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    function automatic logic [1:0] gnt_onehot(grant_e g);
        return (g == GrantDm) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-Lite bundle; M drives requests and response-ready, S drives request-ready and responses.
// Pure wiring: no latency, flow control is the plain valid/ready of each channel.
interface axi_lite_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) ();
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    modport M (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport S (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/rv64_rr_arb2.sv
// Two-way grant selector: combinational pick, last-grant register updated on accept.
// Zero latency; the pick holds while accept is low, so a waiting requester is never lost.
module rv64_rr_arb2 import rv64_pkg::*; #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       accept,
    output grant_e     grant
);
    grant_e last;

    always_comb begin
        grant = GrantIm;
        if (req == 2'b11) begin
            grant = (FIXED_PRIO != 0 || last == GrantIm) ? GrantDm : GrantIm;
        end else if (req[1]) begin
            grant = GrantDm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last <= GrantIm;
        end else if (accept) begin
            last <= grant;
        end
    end
endmodule

// File: rtl/rv64_mem_arbiter.sv
// 2:1 AXI-Lite arbiter (im/dm -> m), independent read and write engines, one outstanding each.
// AR accept to R valid is 4 cycles unstalled; every handshake output is registered and holds under backpressure.
module rv64_mem_arbiter import rv64_pkg::*; #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic   clk,
    input  logic   rstn,
    axi_lite_if.S  s_im,
    axi_lite_if.S  s_dm,
    axi_lite_if.M  m
);
    rd_state_e             rd_state;
    grant_e                rd_gnt, rd_pick;
    logic [1:0]            rd_req, ar_rdy, r_vld;
    logic [ADDR_W-1:0]     ar_addr;
    logic [2:0]            ar_prot;
    logic [DATA_W-1:0]     r_data;
    logic [1:0]            r_resp;
    logic                  m_arvalid, m_rready, r_done;

    wr_state_e             wr_state;
    grant_e                wr_gnt, wr_pick;
    logic [1:0]            wr_req, aw_rdy, b_vld;
    logic [ADDR_W-1:0]     aw_addr;
    logic [2:0]            aw_prot;
    logic [DATA_W-1:0]     w_data;
    logic [DATA_W/8-1:0]   w_strb;
    logic [1:0]            b_resp;
    logic                  m_awvalid, m_wvalid, m_bready;
    logic                  aw_done, w_done, aw_fin, w_fin, b_done;

    assign rd_req = {s_dm.arvalid, s_im.arvalid};
    // A write requester only competes once it presents both address and data.
    assign wr_req = {s_dm.awvalid & s_dm.wvalid, s_im.awvalid & s_im.wvalid};
    assign r_done = (r_vld[0] & s_im.rready) | (r_vld[1] & s_dm.rready);
    assign b_done = (b_vld[0] & s_im.bready) | (b_vld[1] & s_dm.bready);
    assign aw_fin = aw_done | (m_awvalid & m.awready);
    assign w_fin  = w_done  | (m_wvalid  & m.wready);

    rv64_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_rd_arb (
        .clk(clk), .rstn(rstn), .req(rd_req),
        .accept(rd_state == R_IDLE && rd_req != 2'b00), .grant(rd_pick)
    );

    rv64_rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_wr_arb (
        .clk(clk), .rstn(rstn), .req(wr_req),
        .accept(wr_state == W_IDLE && wr_req != 2'b00), .grant(wr_pick)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_state  <= R_IDLE;
            rd_gnt    <= GrantIm;
            ar_addr   <= '0;
            ar_prot   <= '0;
            r_data    <= '0;
            r_resp    <= OKAY;
            ar_rdy    <= 2'b00;
            r_vld     <= 2'b00;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
        end else begin
            ar_rdy <= 2'b00;
            case (rd_state)
                R_IDLE: if (rd_req != 2'b00) begin
                    rd_gnt   <= rd_pick;
                    ar_addr  <= (rd_pick == GrantDm) ? s_dm.araddr : s_im.araddr;
                    ar_prot  <= (rd_pick == GrantDm) ? s_dm.arprot : s_im.arprot;
                    ar_rdy   <= gnt_onehot(rd_pick);
                    rd_state <= R_ADDR;
                end
                R_ADDR: if (m_arvalid && m.arready) begin
                    m_arvalid <= 1'b0;
                    rd_state  <= R_DATA;
                end else begin
                    m_arvalid <= 1'b1;
                end
                R_DATA: if (m_rready && m.rvalid) begin
                    r_data   <= m.rdata;
                    r_resp   <= m.rresp;
                    m_rready <= 1'b0;
                    r_vld    <= gnt_onehot(rd_gnt);
                    rd_state <= R_RESP;
                end else begin
                    m_rready <= 1'b1;
                end
                R_RESP: if (r_done) begin
                    r_vld    <= 2'b00;
                    rd_state <= R_IDLE;
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_state  <= W_IDLE;
            wr_gnt    <= GrantIm;
            aw_addr   <= '0;
            aw_prot   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
            b_resp    <= OKAY;
            aw_rdy    <= 2'b00;
            b_vld     <= 2'b00;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            aw_rdy <= 2'b00;
            case (wr_state)
                W_IDLE: if (wr_req != 2'b00) begin
                    wr_gnt   <= wr_pick;
                    aw_addr  <= (wr_pick == GrantDm) ? s_dm.awaddr : s_im.awaddr;
                    aw_prot  <= (wr_pick == GrantDm) ? s_dm.awprot : s_im.awprot;
                    w_data   <= (wr_pick == GrantDm) ? s_dm.wdata  : s_im.wdata;
                    w_strb   <= (wr_pick == GrantDm) ? s_dm.wstrb  : s_im.wstrb;
                    aw_rdy   <= gnt_onehot(wr_pick);
                    wr_state <= W_REQ;
                end
                W_REQ: if (aw_fin && w_fin) begin
                    m_awvalid <= 1'b0;
                    m_wvalid  <= 1'b0;
                    aw_done   <= 1'b0;
                    w_done    <= 1'b0;
                    wr_state  <= W_RESP;
                end else begin
                    // AW and W retire independently; each valid drops after its own handshake.
                    m_awvalid <= !aw_fin;
                    aw_done   <= aw_fin;
                    m_wvalid  <= !w_fin;
                    w_done    <= w_fin;
                end
                W_RESP: if (m_bready && m.bvalid) begin
                    b_resp   <= m.bresp;
                    m_bready <= 1'b0;
                    b_vld    <= gnt_onehot(wr_gnt);
                    wr_state <= W_BACK;
                end else begin
                    m_bready <= 1'b1;
                end
                W_BACK: if (b_done) begin
                    b_vld    <= 2'b00;
                    wr_state <= W_IDLE;
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    assign s_im.arready = ar_rdy[0];
    assign s_dm.arready = ar_rdy[1];
    assign s_im.rvalid  = r_vld[0];
    assign s_dm.rvalid  = r_vld[1];
    assign s_im.rdata   = r_data;
    assign s_dm.rdata   = r_data;
    assign s_im.rresp   = r_resp;
    assign s_dm.rresp   = r_resp;
    assign s_im.awready = aw_rdy[0];
    assign s_dm.awready = aw_rdy[1];
    assign s_im.wready  = aw_rdy[0];
    assign s_dm.wready  = aw_rdy[1];
    assign s_im.bvalid  = b_vld[0];
    assign s_dm.bvalid  = b_vld[1];
    assign s_im.bresp   = b_resp;
    assign s_dm.bresp   = b_resp;

    assign m.arvalid = m_arvalid;
    assign m.araddr  = ar_addr;
    assign m.arprot  = ar_prot;
    assign m.rready  = m_rready;
    assign m.awvalid = m_awvalid;
    assign m.awaddr  = aw_addr;
    assign m.awprot  = aw_prot;
    assign m.wvalid  = m_wvalid;
    assign m.wdata   = w_data;
    assign m.wstrb   = w_strb;
    assign m.bready  = m_bready;
endmodule

// File: tb/tb_rv64_mem_arbiter.sv
// Directed bench for rv64_mem_arbiter: round-robin instance plus a fixed-priority instance,
// each with a small registered memory model on its downstream port.
module tb_rv64_mem_arbiter;
    import rv64_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    axi_lite_if im_if ();
    axi_lite_if dm_if ();
    axi_lite_if m_if ();
    axi_lite_if im2_if ();
    axi_lite_if dm2_if ();
    axi_lite_if m2_if ();

    rv64_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(0)) dut (
        .clk(clk), .rstn(rstn), .s_im(im_if), .s_dm(dm_if), .m(m_if)
    );
    rv64_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rstn(rstn), .s_im(im2_if), .s_dm(dm2_if), .m(m2_if)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream memory model: AR/AW/W always-or-tb-controlled ready, R and B one cycle after acceptance.
    logic [63:0] rd_data_cfg = 64'h0;
    logic [1:0]  rd_resp_cfg = 2'b00;
    logic        r_stall = 1'b0;
    logic        mem_rv, aw_seen, w_seen, aw_hs, w_hs;
    logic [63:0] ar_log[$];
    int          aw_cnt = 0;
    int          w_cnt = 0;
    logic [63:0] aw_last, w_last;
    logic [7:0]  strb_last;

    assign m_if.rvalid = mem_rv & ~r_stall;
    assign aw_hs = m_if.awvalid & m_if.awready;
    assign w_hs  = m_if.wvalid & m_if.wready;

    always @(posedge clk) begin
        if (!rstn) begin
            mem_rv      <= 1'b0;
            m_if.bvalid <= 1'b0;
            aw_seen     <= 1'b0;
            w_seen      <= 1'b0;
        end else begin
            if (m_if.arvalid && m_if.arready) begin
                ar_log.push_back(m_if.araddr);
                mem_rv     <= 1'b1;
                m_if.rdata <= rd_data_cfg;
                m_if.rresp <= rd_resp_cfg;
            end else if (m_if.rvalid && m_if.rready) begin
                mem_rv <= 1'b0;
            end
            if (aw_hs) begin aw_cnt++; aw_last <= m_if.awaddr; end
            if (w_hs) begin w_cnt++; w_last <= m_if.wdata; strb_last <= m_if.wstrb; end
            if ((aw_seen || aw_hs) && (w_seen || w_hs)) begin
                m_if.bvalid <= 1'b1;
                aw_seen     <= 1'b0;
                w_seen      <= 1'b0;
            end else begin
                aw_seen <= aw_seen | aw_hs;
                w_seen  <= w_seen | w_hs;
                if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
            end
        end
    end

    logic        mem2_rv;
    logic [63:0] ar_log2[$];
    assign m2_if.rvalid = mem2_rv;
    always @(posedge clk) begin
        if (!rstn) mem2_rv <= 1'b0;
        else if (m2_if.arvalid && m2_if.arready) begin
            ar_log2.push_back(m2_if.araddr);
            mem2_rv <= 1'b1;
        end else if (m2_if.rvalid && m2_if.rready) mem2_rv <= 1'b0;
    end

    // Requester-side driver state for the round-robin instance.
    logic [63:0] im_rq[$], dm_rq[$];
    bit          im_arh, dm_arh, im_awh, dm_awh;
    int          im_rc = 0, dm_rc = 0, dm_bc = 0;
    logic [63:0] im_rd;
    logic [1:0]  im_rr, dm_rr, dm_br;
    bit          overlap, im_wr_seen, dm_rv_seen;

    task automatic step();
        @(posedge clk); #1;
        if (im_arh) im_if.arvalid = 1'b0;
        if (dm_arh) dm_if.arvalid = 1'b0;
        if (!im_if.arvalid && im_rq.size() > 0) begin im_if.araddr = im_rq.pop_front(); im_if.arvalid = 1'b1; end
        if (!dm_if.arvalid && dm_rq.size() > 0) begin dm_if.araddr = dm_rq.pop_front(); dm_if.arvalid = 1'b1; end
        if (im_awh) begin im_if.awvalid = 1'b0; im_if.wvalid = 1'b0; end
        if (dm_awh) begin dm_if.awvalid = 1'b0; dm_if.wvalid = 1'b0; end
        im_arh = im_if.arvalid && im_if.arready;
        dm_arh = dm_if.arvalid && dm_if.arready;
        im_awh = im_if.awvalid && im_if.awready && im_if.wvalid && im_if.wready;
        dm_awh = dm_if.awvalid && dm_if.awready && dm_if.wvalid && dm_if.wready;
        if (im_if.rvalid && im_if.rready) begin im_rc++; im_rd = im_if.rdata; im_rr = im_if.rresp; end
        if (dm_if.rvalid && dm_if.rready) begin dm_rc++; dm_rr = dm_if.rresp; end
        if (dm_if.bvalid && dm_if.bready) begin dm_bc++; dm_br = dm_if.bresp; end
        if (im_if.bvalid || im_if.awready || im_if.wready) im_wr_seen = 1'b1;
        if (dm_if.rvalid) dm_rv_seen = 1'b1;
        if ((m_if.arvalid || m_if.rready) && (m_if.awvalid || m_if.wvalid || m_if.bready)) overlap = 1'b1;
    endtask

    function automatic logic [14:0] outs();
        return {im_if.arready, im_if.awready, im_if.wready, im_if.rvalid, im_if.bvalid,
                dm_if.arready, dm_if.awready, dm_if.wready, dm_if.rvalid, dm_if.bvalid,
                m_if.arvalid, m_if.awvalid, m_if.wvalid, m_if.rready, m_if.bready};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int n, base, rc0, dc0, bc0, aw0, w0;
        bit im2_h, dm2_h;
        im_if.arvalid = 0; im_if.araddr = 0; im_if.arprot = 0; im_if.rready = 1;
        im_if.awvalid = 0; im_if.awaddr = 0; im_if.awprot = 0; im_if.wvalid = 0;
        im_if.wdata = 0; im_if.wstrb = 0; im_if.bready = 1;
        dm_if.arvalid = 0; dm_if.araddr = 0; dm_if.arprot = 0; dm_if.rready = 1;
        dm_if.awvalid = 0; dm_if.awaddr = 0; dm_if.awprot = 0; dm_if.wvalid = 0;
        dm_if.wdata = 0; dm_if.wstrb = 0; dm_if.bready = 1;
        m_if.arready = 1; m_if.awready = 1; m_if.wready = 1; m_if.bresp = 2'b00;
        m_if.rdata = 0; m_if.rresp = 0;
        im2_if.arvalid = 0; im2_if.araddr = 0; im2_if.arprot = 0; im2_if.rready = 1;
        im2_if.awvalid = 0; im2_if.awaddr = 0; im2_if.awprot = 0; im2_if.wvalid = 0;
        im2_if.wdata = 0; im2_if.wstrb = 0; im2_if.bready = 1;
        dm2_if.arvalid = 0; dm2_if.araddr = 0; dm2_if.arprot = 0; dm2_if.rready = 1;
        dm2_if.awvalid = 0; dm2_if.awaddr = 0; dm2_if.awprot = 0; dm2_if.wvalid = 0;
        dm2_if.wdata = 0; dm2_if.wstrb = 0; dm2_if.bready = 1;
        m2_if.arready = 1; m2_if.awready = 0; m2_if.wready = 0; m2_if.bvalid = 0;
        m2_if.bresp = 0; m2_if.rdata = 0; m2_if.rresp = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 64'(outs()), 64'd0);
        check("reset_rdata", im_if.rdata, 64'd0);
        rstn = 1'b1;

        // Single fetch: arready to rvalid is 4 cycles, dm sees nothing.
        rd_data_cfg = 64'h13; rd_resp_cfg = 2'b00; dm_rv_seen = 0;
        im_rq.push_back(64'h1000);
        for (int i = 0; i < 20 && !im_if.arready; i++) step();
        check("fetch_arready", 64'(im_if.arready), 64'd1);
        n = 0;
        while (n < 20 && !im_if.rvalid) begin step(); n++; end
        check("fetch_latency", 64'(n), 64'd4);
        check("fetch_rdata", im_if.rdata, 64'h13);
        check("fetch_rresp", 64'(im_if.rresp), 64'd0);
        step();
        check("fetch_rvalid_drop", 64'(im_if.rvalid), 64'd0);
        check("fetch_dm_quiet", 64'(dm_rv_seen), 64'd0);

        // Conflict: dm wins first, then im wins the repeat conflict against dm's next read.
        base = ar_log.size(); rc0 = im_rc; dc0 = dm_rc;
        im_rq.push_back(64'h2000);
        dm_rq.push_back(64'h8000);
        dm_rq.push_back(64'h8008);
        for (int i = 0; i < 80 && !(im_rc == rc0 + 1 && dm_rc == dc0 + 2); i++) step();
        check("rr_done", 64'(ar_log.size() - base), 64'd3);
        check("rr_first", ar_log[base], 64'h8000);
        check("rr_second", ar_log[base+1], 64'h2000);
        check("rr_third", ar_log[base+2], 64'h8008);

        // Fixed priority instance: dm keeps winning while it keeps asking.
        im2_if.araddr = 64'h2000; im2_if.arvalid = 1;
        dm2_if.araddr = 64'h8000; dm2_if.arvalid = 1;
        im2_h = 0; dm2_h = 0;
        for (int i = 0; i < 80 && ar_log2.size() < 3; i++) begin
            @(posedge clk); #1;
            if (im2_h) im2_if.arvalid = 0;
            if (dm2_h) begin
                if (dm2_if.araddr == 64'h8000) dm2_if.araddr = 64'h8008;
                else dm2_if.arvalid = 0;
            end
            im2_h = im2_if.arvalid && im2_if.arready;
            dm2_h = dm2_if.arvalid && dm2_if.arready;
        end
        check("fp_count", 64'(ar_log2.size()), 64'd3);
        check("fp_first", ar_log2[0], 64'h8000);
        check("fp_second", ar_log2[1], 64'h8008);
        check("fp_third", ar_log2[2], 64'h2000);

        // Downstream AR backpressure for 5 cycles.
        m_if.arready = 0; base = ar_log.size(); rc0 = im_rc;
        im_rq.push_back(64'h3000);
        for (int i = 0; i < 20 && !m_if.arvalid; i++) step();
        for (int i = 0; i < 5; i++) begin
            check("bp_arvalid", 64'(m_if.arvalid), 64'd1);
            check("bp_araddr", m_if.araddr, 64'h3000);
            step();
        end
        m_if.arready = 1;
        for (int i = 0; i < 20 && im_rc == rc0; i++) step();
        check("bp_single_ar", 64'(ar_log.size() - base), 64'd1);
        check("bp_addr", ar_log[base], 64'h3000);

        // Store: W accepted downstream 3 cycles before AW.
        m_if.awready = 0; m_if.wready = 1; im_wr_seen = 0;
        aw0 = aw_cnt; w0 = w_cnt; bc0 = dm_bc;
        dm_if.awaddr = 64'h8010; dm_if.wdata = 64'hDEADBEEF_CAFEF00D; dm_if.wstrb = 8'h0F;
        dm_if.awvalid = 1; dm_if.wvalid = 1;
        for (int i = 0; i < 20 && w_cnt == w0; i++) step();
        step(); step();
        m_if.awready = 1;
        for (int i = 0; i < 30 && dm_bc == bc0; i++) step();
        check("st_aw_once", 64'(aw_cnt - aw0), 64'd1);
        check("st_w_once", 64'(w_cnt - w0), 64'd1);
        check("st_awaddr", aw_last, 64'h8010);
        check("st_wdata", w_last, 64'hDEADBEEF_CAFEF00D);
        check("st_wstrb", 64'(strb_last), 64'h0F);
        check("st_bresp", 64'(dm_br), 64'd0);
        check("st_im_idle", 64'(im_wr_seen), 64'd0);

        // Concurrent dm store and im fetch.
        overlap = 0; rd_data_cfg = 64'h00A00093; rc0 = im_rc; bc0 = dm_bc;
        dm_if.awaddr = 64'h8020; dm_if.wdata = 64'h11223344_55667788; dm_if.wstrb = 8'hFF;
        dm_if.awvalid = 1; dm_if.wvalid = 1;
        im_rq.push_back(64'h1004);
        for (int i = 0; i < 40 && !(im_rc == rc0 + 1 && dm_bc == bc0 + 1); i++) step();
        check("cc_overlap", 64'(overlap), 64'd1);
        check("cc_rdata", im_rd, 64'h00A00093);
        check("cc_rresp", 64'(im_rr), 64'd0);
        check("cc_awaddr", aw_last, 64'h8020);
        check("cc_bresp", 64'(dm_br), 64'd0);

        // Error response forwarded unchanged.
        rd_resp_cfg = 2'b10; dc0 = dm_rc;
        dm_rq.push_back(64'h8030);
        for (int i = 0; i < 20 && dm_rc == dc0; i++) step();
        check("err_rresp", 64'(dm_rr), 64'd2);
        rd_resp_cfg = 2'b00;

        // Reset while waiting for R data.
        r_stall = 1;
        im_rq.push_back(64'h1008);
        for (int i = 0; i < 20 && !m_if.rready; i++) step();
        check("rst_in_rdata", 64'(m_if.rready), 64'd1);
        rstn = 0;
        @(posedge clk); #1;
        check("rst_mid_outs", 64'(outs()), 64'd0);
        rstn = 1; r_stall = 0;
        rd_data_cfg = 64'h55;
        im_rq.push_back(64'h100C);
        for (int i = 0; i < 20 && !im_if.arready; i++) step();
        n = 0;
        while (n < 20 && !im_if.rvalid) begin step(); n++; end
        check("post_rst_latency", 64'(n), 64'd4);
        check("post_rst_rdata", im_if.rdata, 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
